// File: rtl/ddr4_v2_2_20_cal_rd_ret_pkg.sv
// Shared types for the calibration read-return router: route encoding and routing rule.
package ddr4_v2_2_20_cal_rd_ret_pkg;

    typedef enum logic [1:0] {
        RT_CAL = 2'd0,
        RT_RMW = 2'd1,
        RT_USR = 2'd2
    } route_t;

    // Calibration owns every beat until calDone; RMW reads then bypass the user FIFO.
    function automatic route_t rd_route(input logic cal_done, input logic rmw);
        if (!cal_done) begin
            return RT_CAL;
        end else if (rmw) begin
            return RT_RMW;
        end
        return RT_USR;
    endfunction

endpackage

// File: rtl/ddr4_v2_2_20_cal_rd_ret_fifo.sv
// Synchronous first-word-fall-through FIFO with a separate level counter and sticky overflow.
module ddr4_v2_2_20_cal_rd_ret_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned LW = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level,
    output logic             ovf
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             do_pop, do_push, drop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == LW'(DEPTH));

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q | drop;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr_q];
    assign level = cnt_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/ddr4_v2_2_20_cal_rd_return.sv
// Read-return router: captures PHY read beats and steers them to calibration compare,
// RMW merge, or a backpressured user return FIFO.
module ddr4_v2_2_20_cal_rd_return
    import ddr4_v2_2_20_cal_rd_ret_pkg::*;
#(
    parameter int unsigned DBAW   = 5,
    parameter int unsigned DBYTES = 4,
    parameter int unsigned DEPTH  = 16,
    parameter real         TCQ    = 0.1,
    localparam int unsigned DW    = DBYTES * 64,
    localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdDataEn,
    input  logic [DBAW-1:0] rdDataAddr,
    input  logic            rdDataEnd,
    input  logic            rdRmw,
    input  logic            rdInj,
    input  logic [DW-1:0]   phy_rd_data,
    input  logic            calDone,
    output logic            cal_rd_valid,
    output logic [DW-1:0]   cal_rd_data,
    output logic            rmw_valid,
    output logic [DBAW-1:0] rmw_addr,
    output logic [DW-1:0]   rmw_data,
    output logic            usr_rd_valid,
    input  logic            usr_rd_ready,
    output logic [DW-1:0]   usr_rd_data,
    output logic [DBAW-1:0] usr_rd_addr,
    output logic            usr_rd_end,
    output logic            usr_rd_inj,
    output logic [LW-1:0]   fifo_level,
    output logic            ovf_err
);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || TCQ < 0.0) begin : g_param_chk
        $error("ddr4_v2_2_20_cal_rd_return: DEPTH must be a power of 2 >= 4, TCQ >= 0");
    end

    typedef struct packed {
        logic            inj;
        logic            last;
        logic [DBAW-1:0] addr;
        logic [DW-1:0]   data;
    } usr_entry_t;

    usr_entry_t cap_q, cap_d;
    logic       cap_vld_q;
    logic       cap_rmw_q, cap_rmw_d;
    logic       cap_cal_q, cap_cal_d;
    route_t     route;

    logic            cal_vld_q, cal_vld_d;
    logic [DW-1:0]   cal_data_q, cal_data_d;
    logic            rmw_vld_q, rmw_vld_d;
    logic [DBAW-1:0] rmw_addr_q, rmw_addr_d;
    logic [DW-1:0]   rmw_data_q, rmw_data_d;

    logic       usr_push, usr_pop;
    logic       fifo_full, fifo_empty, fifo_ovf;
    usr_entry_t head;

    // calDone is sampled with the beat so a same-cycle rise already routes to the user path.
    always_comb begin
        cap_d     = cap_q;
        cap_rmw_d = cap_rmw_q;
        cap_cal_d = cap_cal_q;
        if (rdDataEn) begin
            cap_d.inj  = rdInj;
            cap_d.last = rdDataEnd;
            cap_d.addr = rdDataAddr;
            cap_d.data = phy_rd_data;
            cap_rmw_d  = rdRmw;
            cap_cal_d  = calDone;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_vld_q <= 1'b0;
        end else begin
            cap_vld_q <= rdDataEn;
        end
        cap_q     <= cap_d;
        cap_rmw_q <= cap_rmw_d;
        cap_cal_q <= cap_cal_d;
    end

    assign route    = rd_route(cap_cal_q, cap_rmw_q);
    assign usr_push = cap_vld_q && (route == RT_USR);
    assign usr_pop  = usr_rd_valid & usr_rd_ready;

    always_comb begin
        cal_vld_d  = cap_vld_q && (route == RT_CAL);
        cal_data_d = cal_data_q;
        rmw_vld_d  = cap_vld_q && (route == RT_RMW);
        rmw_addr_d = rmw_addr_q;
        rmw_data_d = rmw_data_q;
        if (cal_vld_d) begin
            cal_data_d = cap_q.data;
        end
        if (rmw_vld_d) begin
            rmw_addr_d = cap_q.addr;
            rmw_data_d = cap_q.data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cal_vld_q  <= 1'b0;
            cal_data_q <= '0;
            rmw_vld_q  <= 1'b0;
            rmw_addr_q <= '0;
            rmw_data_q <= '0;
        end else begin
            cal_vld_q  <= cal_vld_d;
            cal_data_q <= cal_data_d;
            rmw_vld_q  <= rmw_vld_d;
            rmw_addr_q <= rmw_addr_d;
            rmw_data_q <= rmw_data_d;
        end
    end

    ddr4_v2_2_20_cal_rd_ret_fifo #(
        .WIDTH ($bits(usr_entry_t)),
        .DEPTH (DEPTH)
    ) u_usr_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (usr_push),
        .wdata (cap_q),
        .pop   (usr_pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level),
        .ovf   (fifo_ovf)
    );

    assign cal_rd_valid = cal_vld_q;
    assign cal_rd_data  = cal_data_q;
    assign rmw_valid    = rmw_vld_q;
    assign rmw_addr     = rmw_addr_q;
    assign rmw_data     = rmw_data_q;
    assign usr_rd_valid = ~fifo_empty;
    assign usr_rd_data  = head.data;
    assign usr_rd_addr  = head.addr;
    assign usr_rd_end   = head.last;
    assign usr_rd_inj   = head.inj;
    // Full is implied by the level count; the sticky overflow comes straight from the FIFO.
    assign ovf_err      = fifo_ovf | (fifo_ovf & fifo_full);

endmodule
